fdiv_sched: RTL and testbench
=============================

Name: fdiv_sched

Overview:
- Multi-channel clock-enable scheduler built around one shared prescaler running from the 50 MHz board clock.
- Generates up to 4 independently configured square-wave outputs and single-cycle tick strobes for display scan, stopwatch and LED blink logic.
- Channels are reprogrammed at run time through a valid/ready configuration port, so downstream blocks no longer need their own 26-bit dividers.

Parameters:
- PRESCALE, 50000: clk_50mHz cycles per base tick (50000 gives a 1 kHz base). Legal range 2..2^20.
- NCH, 4: number of channels, fixed at 4 in this revision.
- HW, 16: width of the per-channel half-period register, in base ticks.

Ports:
- clk_50mHz  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration port can accept a request.
- cfg_chan  in  2  target channel index.
- cfg_half  in  HW  half-period in base ticks. 0 disables the channel.
- cfg_phase  in  1  initial clk_out level after the request is applied.
- base_tick  out  1  one-cycle strobe every PRESCALE cycles.
- clk_out  out  NCH  per-channel square wave; each level lasts half base ticks.
- tick_out  out  NCH  one-cycle strobe in the same cycle clk_out[i] rises 0->1.
- active  out  NCH  channel i has half != 0.

Behaviour:
- Reset (rst=1 at a clock edge), values seen after that edge:
  - prescaler count = 0, base_tick = 0.
  - All half registers = 0, all channel counters = 0.
  - clk_out = 0, tick_out = 0, active = 0.
  - FSM = IDLE, cfg_ready = 1.
  - Reset is honoured mid-config and mid-period, with no partial state kept.
- Prescaler:
  - 20-bit count runs 0..PRESCALE-1 and wraps to 0.
  - base_tick is registered: it is 1 in the cycle after the count is PRESCALE-1.
  - Period is exactly PRESCALE cycles. The first base_tick appears PRESCALE cycles after reset release.
- Channel i, when half_i != 0, on a cycle with base_tick=1:
  - If cnt_i == half_i-1: cnt_i <= 0 and clk_out[i] toggles. If the toggle is 0->1, tick_out[i] = 1 in that same registered cycle.
  - Otherwise cnt_i increments.
  - Output period = 2*half_i*PRESCALE cycles, 50% duty.
- Channel i, when half_i == 0: cnt_i and clk_out[i] are held at 0 and tick_out[i] stays 0.
- Config FSM, two states:
  - IDLE: cfg_ready=1. On cfg_valid & cfg_ready, latch chan/half/phase and go to APPLY.
  - APPLY (exactly 1 cycle): cfg_ready=0. Write the latched values:
    - half[chan] <= half, cnt[chan] <= 0.
    - clk_out[chan] <= phase, but forced to 0 if half==0.
    - No tick_out is generated by this write.
    - Return to IDLE.
  - Accept-to-effect latency is 2 cycles. Maximum throughput is one request every 2 cycles.
- Simultaneous events:
  - A base_tick in the APPLY cycle is ignored for the channel being written; the config write wins.
  - Other channels process that tick normally.
  - cfg_valid while cfg_ready=0 is not accepted. The requester holds its request, and fields must stay stable until accepted.
- Widths:
  - The counter compare uses HW bits. half=1 toggles on every base tick.
  - Counters never exceed half-1. If half is reduced below the current count, the APPLY-cycle reset to 0 prevents any overrun.
- active[i] = (half_i != 0), registered.

Test Plan:
- Reset/prescaler (PRESCALE=10): release rst, hold cfg_valid=0 -> base_tick pulses at cycles 10, 20, 30; clk_out=0, tick_out=0, active=0 throughout.
- Single channel (PRESCALE=10): write chan=1, half=3, phase=0 -> active[1]=1 two cycles after accept; clk_out[1] period 60 cycles at 50% duty; tick_out[1] is a one-cycle pulse exactly on each rising edge; other channels stay 0.
- Back-to-back config: hold cfg_valid=1 with four different channel writes -> cfg_ready pattern 1,0,1,0...; exactly 4 accepts in 8 cycles; all four channels run at their programmed periods, half=1,2,3,4 giving periods of 20, 40, 60 and 80 cycles.
- Collision: time an accept so APPLY coincides with base_tick for chan 2, which is running with half=2 -> cnt2=0 after APPLY and no toggle that cycle; channel 0 still toggles on the same tick.
- Disable/re-phase: write chan=0, half=0 while clk_out[0]=1 -> clk_out[0]=0 and active[0]=0 two cycles after accept, with no tick_out. Then write half=5, phase=1 -> clk_out[0]=1 immediately with no tick_out; first fall after 5 base ticks.
- Reset mid-operation: assert rst for 1 cycle while in APPLY with two channels running -> all outputs 0 and cfg_ready=1 on the next cycle; the pending write is not applied.

Source files
------------

// File: rtl/fdiv_sched.sv
// Multi-channel clock-enable scheduler: one shared prescaler drives up to four
// programmable square-wave channels, reprogrammed through a valid/ready port.
module fdiv_sched #(
  parameter int PRESCALE = 50000,
  parameter int NCH      = 4,
  parameter int HW       = 16
) (
  input  logic           clk_50mHz,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_chan,
  input  logic [HW-1:0]  cfg_half,
  input  logic           cfg_phase,
  output logic           base_tick,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick_out,
  output logic [NCH-1:0] active
);

  localparam logic [19:0] PS_LAST = 20'(PRESCALE - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, APPLY = 1'b1} state_t;

  state_t         state_r, state_s;
  logic           cfg_ready_s;
  logic           accept_s;
  logic [19:0]    ps_cnt_r;
  logic           base_tick_r;
  logic [1:0]     lat_chan_r;
  logic [HW-1:0]  lat_half_r;
  logic           lat_phase_r;
  logic [HW-1:0]  half_r [NCH];
  logic [HW-1:0]  cnt_r  [NCH];
  logic [NCH-1:0] clk_out_r;
  logic [NCH-1:0] tick_out_r;
  logic [NCH-1:0] active_r;

  // Shared prescaler; base_tick is registered so it lands one cycle after the wrap value
  always_ff @(posedge clk_50mHz) begin
    if (rst) begin
      ps_cnt_r    <= 20'd0;
      base_tick_r <= 1'b0;
    end else if (ps_cnt_r == PS_LAST) begin
      ps_cnt_r    <= 20'd0;
      base_tick_r <= 1'b1;
    end else begin
      ps_cnt_r    <= ps_cnt_r + 20'd1;
      base_tick_r <= 1'b0;
    end
  end

  // Config FSM state register
  always_ff @(posedge clk_50mHz) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Config FSM next-state logic
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE:    state_s = accept_s ? APPLY : IDLE;
      APPLY:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Config FSM outputs
  always_comb begin
    cfg_ready_s = 1'b0;
    case (state_r)
      IDLE:    cfg_ready_s = 1'b1;
      APPLY:   cfg_ready_s = 1'b0;
      default: cfg_ready_s = 1'b0;
    endcase
    accept_s = cfg_valid & cfg_ready_s;
  end

  // Request latch, captured on accept and consumed during APPLY
  always_ff @(posedge clk_50mHz) begin
    if (rst) begin
      lat_chan_r  <= 2'd0;
      lat_half_r  <= '0;
      lat_phase_r <= 1'b0;
    end else if (accept_s) begin
      lat_chan_r  <= cfg_chan;
      lat_half_r  <= cfg_half;
      lat_phase_r <= cfg_phase;
    end
  end

  // Per-channel counters; an APPLY write to a channel overrides that channel's base tick
  always_ff @(posedge clk_50mHz) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        half_r[i]     <= '0;
        cnt_r[i]      <= '0;
        clk_out_r[i]  <= 1'b0;
        tick_out_r[i] <= 1'b0;
        active_r[i]   <= 1'b0;
      end else if ((state_r == APPLY) && (lat_chan_r == 2'(i))) begin
        half_r[i]     <= lat_half_r;
        cnt_r[i]      <= '0;
        clk_out_r[i]  <= lat_phase_r & (lat_half_r != '0);
        tick_out_r[i] <= 1'b0;
        active_r[i]   <= (lat_half_r != '0);
      end else if (half_r[i] == '0) begin
        cnt_r[i]      <= '0;
        clk_out_r[i]  <= 1'b0;
        tick_out_r[i] <= 1'b0;
        active_r[i]   <= 1'b0;
      end else if (base_tick_r) begin
        active_r[i] <= 1'b1;
        if (cnt_r[i] == half_r[i] - HW'(1)) begin
          cnt_r[i]      <= '0;
          clk_out_r[i]  <= ~clk_out_r[i];
          tick_out_r[i] <= ~clk_out_r[i];
        end else begin
          cnt_r[i]      <= cnt_r[i] + HW'(1);
          tick_out_r[i] <= 1'b0;
        end
      end else begin
        tick_out_r[i] <= 1'b0;
        active_r[i]   <= 1'b1;
      end
    end
  end

  assign cfg_ready = cfg_ready_s;
  assign base_tick = base_tick_r;
  assign clk_out   = clk_out_r;
  assign tick_out  = tick_out_r;
  assign active    = active_r;

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed bench for fdiv_sched with PRESCALE=10; expected waveforms are hand-derived
// edge numbers counted from the last reset edge.
module tb_fdiv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_chan;
  logic [15:0] cfg_half;
  logic        cfg_phase;
  logic        base_tick;
  logic [3:0]  clk_out;
  logic [3:0]  tick_out;
  logic [3:0]  active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  fdiv_sched #(.PRESCALE(10), .NCH(4), .HW(16)) dut (
    .clk_50mHz (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_half  (cfg_half),
    .cfg_phase (cfg_phase),
    .base_tick (base_tick),
    .clk_out   (clk_out),
    .tick_out  (tick_out),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    step(1);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [15:0] h, input logic p);
    cfg_valid = v;
    cfg_chan  = ch;
    cfg_half  = h;
    cfg_phase = p;
  endtask

  // All channels written before edge 11 with phase 0: ticks consumed at edges 11,21,31,...
  function automatic logic exp_clk_b2b(input int h, input int c);
    int n;
    n = (c >= 11) ? ((c - 11) / 10 + 1) : 0;
    return ((n / h) % 2) == 1;
  endfunction

  function automatic logic exp_tick_b2b(input int h, input int c);
    int n;
    n = (c >= 11) ? ((c - 11) / 10 + 1) : 0;
    return (c >= 11) && ((c - 11) % 10 == 0) && (n % h == 0) && (((n / h) % 2) == 1);
  endfunction

  initial begin
    logic [3:0] ec;
    logic [3:0] et;
    int acc;
    logic [15:0] halves [4];
    halves[0] = 16'd1; halves[1] = 16'd2; halves[2] = 16'd3; halves[3] = 16'd4;

    // Reset and free-running prescaler
    rst = 1'b1;
    drive(1'b0, 2'd0, 16'd0, 1'b0);
    step(2);
    rst = 1'b0;
    cyc = 0;
    check_val("rst_ready",  32'(cfg_ready), 32'd1);
    check_val("rst_btick",  32'(base_tick), 32'd0);
    check_val("rst_clkout", 32'(clk_out),   32'd0);
    check_val("rst_active", 32'(active),    32'd0);
    while (cyc < 30) begin
      step(1);
      check_val("ps_btick", 32'(base_tick), 32'((cyc % 10) == 0));
      check_val("ps_clkout", 32'(clk_out), 32'd0);
      check_val("ps_tick", 32'(tick_out), 32'd0);
      check_val("ps_active", 32'(active), 32'd0);
    end

    // Single channel: chan1 half3 phase0, accepted at edge 31, applied at edge 32
    drive(1'b1, 2'd1, 16'd3, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    check_val("sc_ready_apply", 32'(cfg_ready), 32'd0);
    check_val("sc_active_early", 32'(active), 32'd0);
    step(1);
    check_val("sc_active", 32'(active), 32'b0010);
    check_val("sc_ready_back", 32'(cfg_ready), 32'd1);
    while (cyc < 130) begin
      step(1);
      ec = {2'b00, ((cyc >= 61 && cyc < 91) || (cyc >= 121 && cyc < 151)), 1'b0};
      et = {2'b00, (cyc == 61 || cyc == 121), 1'b0};
      check_val("sc_clkout", 32'(clk_out), 32'(ec));
      check_val("sc_tick", 32'(tick_out), 32'(et));
    end

    // Back-to-back config with cfg_valid held high
    do_reset();
    check_val("b2b_rst_clk", 32'(clk_out), 32'd0);
    check_val("b2b_rst_act", 32'(active), 32'd0);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'(k / 2), halves[k / 2], 1'b0);
      check_val("b2b_ready", 32'(cfg_ready), 32'((k % 2) == 0));
      if (cfg_ready) acc++;
      step(1);
    end
    cfg_valid = 1'b0;
    check_val("b2b_accepts", 32'(acc), 32'd4);
    check_val("b2b_active", 32'(active), 32'b1111);
    while (cyc < 170) begin
      step(1);
      for (int ch = 0; ch < 4; ch++) begin
        ec[ch] = exp_clk_b2b(ch + 1, cyc);
        et[ch] = exp_tick_b2b(ch + 1, cyc);
      end
      check_val("b2b_clkout", 32'(clk_out), 32'(ec));
      check_val("b2b_tick", 32'(tick_out), 32'(et));
    end

    // Collision: ch0 half1 and ch2 half2 running, rewrite ch2 in the APPLY cycle of edge 61
    do_reset();
    drive(1'b1, 2'd0, 16'd1, 1'b0);
    step(1);
    drive(1'b1, 2'd2, 16'd2, 1'b0);
    step(2);
    cfg_valid = 1'b0;
    step(1);
    check_val("col_active", 32'(active), 32'b0101);
    step(17);
    check_val("col_c21_clk", 32'(clk_out), 32'b0100);
    check_val("col_c21_tick", 32'(tick_out), 32'b0100);
    step(38);
    drive(1'b1, 2'd2, 16'd2, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    check_val("col_c60_clk", 32'(clk_out), 32'b0001);
    check_val("col_c60_btick", 32'(base_tick), 32'd1);
    step(1);
    check_val("col_c61_clk", 32'(clk_out), 32'b0000);
    check_val("col_c61_tick", 32'(tick_out), 32'b0000);
    step(10);
    check_val("col_c71_clk", 32'(clk_out), 32'b0001);
    step(10);
    check_val("col_c81_clk", 32'(clk_out), 32'b0100);
    check_val("col_c81_tick", 32'(tick_out), 32'b0100);

    // Disable ch0 while its output is high, then re-enable with phase 1
    step(10);
    check_val("dis_c91_clk", 32'(clk_out), 32'b0101);
    drive(1'b1, 2'd0, 16'd0, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    check_val("dis_c92_clk", 32'(clk_out), 32'b0101);
    check_val("dis_c92_act", 32'(active), 32'b0101);
    step(1);
    check_val("dis_c93_clk", 32'(clk_out), 32'b0100);
    check_val("dis_c93_act", 32'(active), 32'b0100);
    check_val("dis_c93_tick", 32'(tick_out), 32'b0000);
    drive(1'b1, 2'd0, 16'd5, 1'b1);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    check_val("rph_c95_clk", 32'(clk_out), 32'b0101);
    check_val("rph_c95_tick", 32'(tick_out), 32'b0000);
    check_val("rph_c95_act", 32'(active), 32'b0101);
    while (cyc < 200) begin
      step(1);
      check_val("rph_clk0", 32'(clk_out[0]), 32'((cyc < 141) || (cyc >= 191)));
      check_val("rph_tick0", 32'(tick_out[0]), 32'(cyc == 191));
    end

    // Reset asserted during APPLY: pending write to ch3 is dropped
    drive(1'b1, 2'd3, 16'd7, 1'b1);
    step(1);
    check_val("mr_ready_apply", 32'(cfg_ready), 32'd0);
    rst = 1'b1;
    cfg_valid = 1'b0;
    step(1);
    rst = 1'b0;
    cyc = 0;
    check_val("mr_clk", 32'(clk_out), 32'd0);
    check_val("mr_tick", 32'(tick_out), 32'd0);
    check_val("mr_act", 32'(active), 32'd0);
    check_val("mr_ready", 32'(cfg_ready), 32'd1);
    check_val("mr_btick", 32'(base_tick), 32'd0);
    step(3);
    check_val("mr_act_later", 32'(active), 32'd0);
    check_val("mr_clk_later", 32'(clk_out), 32'd0);
    step(6);
    check_val("mr_btick9", 32'(base_tick), 32'd0);
    step(1);
    check_val("mr_btick10", 32'(base_tick), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
